// File: rtl/set_cov_pkg.sv
// rtl/set_cov_pkg.sv - shared types, defaults and helpers for the set coverage collector
package set_cov_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Increment that parks at lim instead of wrapping; callers zero-extend to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/set_match_stage.sv
// rtl/set_match_stage.sv - first pipeline stage: parallel table compare and registered match vector
module set_match_stage
  import set_cov_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_value,
  input  logic [DEPTH-1:0][WIDTH-1:0]  tbl,
  input  logic [DEPTH-1:0]             entry_valid,
  output logic                         s1_valid,
  output logic [DEPTH-1:0]             match_vec
);

  logic [DEPTH-1:0] match_raw;

  // One comparator per entry; unloaded entries never match.
  always_comb begin
    match_raw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_raw[i] = entry_valid[i] && (tbl[i] == in_value);
    end
  end

  // Stage register; a reset drops whatever sample was in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      match_vec <= '0;
    end else begin
      s1_valid  <= in_valid;
      match_vec <= in_valid ? match_raw : '0;
    end
  end

endmodule

// File: rtl/set_coverage_collector.sv
// rtl/set_coverage_collector.sv - programmable set table with pipelined membership coverage
module set_coverage_collector
  import set_cov_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_data,
  input  logic                     cfg_clr,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     smp_valid,
  output logic                     smp_ready,
  input  logic [WIDTH-1:0]         smp_value,
  output logic [CW-1:0]            hit_count,
  output logic [CW-1:0]            miss_count,
  output logic [DEPTH-1:0]         hit_map,
  output logic [DEPTH-1:0]         entry_valid,
  output logic                     covered_all,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t                       state, state_n;
  logic [DEPTH-1:0][WIDTH-1:0]  tbl;
  logic [DEPTH-1:0]             entry_valid_n;
  logic                         s1_valid;
  logic [DEPTH-1:0]             match_vec;
  logic                         accept;

  assign smp_ready   = (state == RUN);
  assign busy        = (state != IDLE);
  assign accept      = smp_valid && smp_ready;
  assign covered_all = ((hit_map & entry_valid) == entry_valid) && (|entry_valid);

  set_match_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (accept),
    .in_value    (smp_value),
    .tbl         (tbl),
    .entry_valid (entry_valid),
    .s1_valid    (s1_valid),
    .match_vec   (match_vec)
  );

  // Next-state, done pulse and table-valid update (clear first, then write).
  always_comb begin
    state_n       = state;
    done          = 1'b0;
    entry_valid_n = entry_valid;
    if (cfg_clr) entry_valid_n = '0;
    if (cfg_we)  entry_valid_n[cfg_addr] = 1'b1;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (stop)  state_n = FLUSH;
      FLUSH: begin
        if (!s1_valid) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Table storage needs no reset: stale entries are masked by entry_valid.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we) tbl[cfg_addr] <= cfg_data;
  end

  // State, table-valid bits and second-stage accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      entry_valid <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      hit_map     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) entry_valid <= entry_valid_n;
      if (state == IDLE && start) begin
        hit_count  <= '0;
        miss_count <= '0;
        hit_map    <= '0;
      end else if (s1_valid) begin
        if (|match_vec) hit_count  <= CW'(sat_inc(32'(hit_count), 32'(CNT_MAX)));
        else            miss_count <= CW'(sat_inc(32'(miss_count), 32'(CNT_MAX)));
        hit_map <= hit_map | match_vec;
      end
    end
  end

endmodule

// File: tb/tb_set_coverage_collector.sv
// tb/tb_set_coverage_collector.sv - scoreboard bench for set_coverage_collector
module tb_set_coverage_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_clr, start, stop, smp_valid;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data, smp_value;
  logic        smp_ready, covered_all, busy, done;
  logic [15:0] hit_count, miss_count;
  logic [7:0]  hit_map, entry_valid;
  logic        smp_ready4, covered_all4, busy4, done4;
  logic [3:0]  hit_count4, miss_count4;
  logic [7:0]  hit_map4, entry_valid4;

  always #5 clk = ~clk;

  set_coverage_collector #(.WIDTH(8), .DEPTH(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_clr(cfg_clr), .start(start), .stop(stop), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .smp_value(smp_value), .hit_count(hit_count),
    .miss_count(miss_count), .hit_map(hit_map), .entry_valid(entry_valid),
    .covered_all(covered_all), .busy(busy), .done(done)
  );

  set_coverage_collector #(.WIDTH(8), .DEPTH(8), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_clr(cfg_clr), .start(start), .stop(stop), .smp_valid(smp_valid),
    .smp_ready(smp_ready4), .smp_value(smp_value), .hit_count(hit_count4),
    .miss_count(miss_count4), .hit_map(hit_map4), .entry_valid(entry_valid4),
    .covered_all(covered_all4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [15:0] hit;
    logic [15:0] miss;
    logic [7:0]  map;
    logic [7:0]  ev;
    logic        cov;
    logic [3:0]  hit4;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] smp_q[$];
  logic [7:0] m_tab[8];
  logic [7:0] m_ev, m_map;
  int         m_hit, m_miss, m_hit4;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input logic clr);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_clr = clr;
    cyc();
    cfg_we = 1'b0; cfg_clr = 1'b0;
    if (clr) m_ev = '0;
    m_tab[a] = d;
    m_ev[a]  = 1'b1;
  endtask

  task automatic cfg_clear();
    cfg_clr = 1'b1;
    cyc();
    cfg_clr = 1'b0;
    m_ev = '0;
  endtask

  task automatic model_sample(input logic [7:0] v);
    logic [7:0] mv;
    mv = '0;
    for (int i = 0; i < 8; i++) if (m_ev[i] && m_tab[i] == v) mv[i] = 1'b1;
    if (|mv) begin
      m_hit++;
      if (m_hit4 < 15) m_hit4++;
    end else begin
      m_miss++;
    end
    m_map = m_map | mv;
  endtask

  task automatic push_expected();
    exp_t e;
    e.hit  = 16'(m_hit);
    e.miss = 16'(m_miss);
    e.map  = m_map;
    e.ev   = m_ev;
    e.cov  = ((m_map & m_ev) == m_ev) && (m_ev != 0);
    e.hit4 = 4'(m_hit4);
    exp_q.push_back(e);
  endtask

  // Waits for done, checks its timing and width, then pops and compares the results.
  task automatic wait_done(input string tag, input bit check_lat);
    int   seen;
    exp_t e;
    seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done) begin
        seen = c;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen != 0), 1);
    if (check_lat && seen != 0) chk({tag, "_done_lat_ok"}, 32'(seen >= 2 && seen <= 3), 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hit"},  32'(hit_count),   32'(e.hit));
      chk({tag, "_miss"}, 32'(miss_count),  32'(e.miss));
      chk({tag, "_map"},  32'(hit_map),     32'(e.map));
      chk({tag, "_ev"},   32'(entry_valid), 32'(e.ev));
      chk({tag, "_cov"},  32'(covered_all), 32'(e.cov));
      chk({tag, "_hit4"}, 32'(hit_count4),  32'(e.hit4));
    end
  endtask

  // Runs one window over smp_q back-to-back; stop rides on the last sample.
  task automatic run_window(input string tag);
    m_hit = 0; m_miss = 0; m_hit4 = 0; m_map = '0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_ready"}, 32'(smp_ready), 1);
    for (int i = 0; i < smp_q.size(); i++) begin
      smp_valid = 1'b1;
      smp_value = smp_q[i];
      stop      = (i == smp_q.size() - 1);
      model_sample(smp_q[i]);
      cyc();
    end
    smp_valid = 1'b0;
    stop      = 1'b0;
    push_expected();
    wait_done(tag, 1'b1);
    smp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_clr = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; stop = 0; smp_valid = 0; smp_value = 0;
    m_ev = '0; m_map = '0; m_hit = 0; m_miss = 0; m_hit4 = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hit", 32'(hit_count), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_map", 32'(hit_map), 0);
    chk("rst_ev", 32'(entry_valid), 0);
    chk("rst_cov", 32'(covered_all), 0);
    chk("rst_ready", 32'(smp_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    cyc();

    for (int i = 0; i < 8; i++) cfg_write(3'(i), 8'(i * 10), 1'b0);
    smp_q = '{8'd10, 8'd35, 8'd70, 8'd0};
    run_window("basic");

    for (int i = 7; i >= 0; i--) smp_q.push_back(8'(i * 10));
    run_window("all");

    cfg_write(3'd0, 8'd0, 1'b1);
    @(negedge clk);
    chk("clr_we_ev", 32'(entry_valid), 32'h01);
    cyc();
    cfg_write(3'd1, 8'd5, 1'b0);
    cfg_write(3'd2, 8'd10, 1'b0);
    cfg_write(3'd3, 8'd15, 1'b0);
    smp_q = '{8'd5, 8'd5, 8'd20};
    run_window("partial");

    cfg_clear();
    cfg_write(3'd0, 8'd5, 1'b0);
    cfg_write(3'd1, 8'd5, 1'b0);
    smp_q = '{8'd5};
    run_window("dup");

    cfg_clear();
    cfg_write(3'd0, 8'd7, 1'b0);
    for (int i = 0; i < 20; i++) smp_q.push_back(8'd7);
    run_window("sat");

    start = 1'b1;
    cyc();
    start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 8'd99;
    smp_valid = 1'b1; smp_value = 8'd7;
    cyc();
    smp_value = 8'd8;
    cyc();
    cfg_we = 1'b0;
    smp_valid = 1'b0;
    @(negedge clk);
    chk("run_cfg_ignored", 32'(entry_valid), 32'(m_ev));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_hit", 32'(hit_count), 0);
    chk("mid_rst_miss", 32'(miss_count), 0);
    chk("mid_rst_map", 32'(hit_map), 0);
    chk("mid_rst_ev", 32'(entry_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(smp_ready), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hit_later", 32'(hit_count), 0);
    m_ev = '0;
    cyc();

    m_hit = 0; m_miss = 0; m_hit4 = 0; m_map = '0;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_run", 32'(busy), 1);
    chk("start_stop_ready", 32'(smp_ready), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    push_expected();
    wait_done("start_stop", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
